// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences fetch/decode/execute/memory for a multi-cycle RV32I/RV64I dataflow
// Ports: clock, reset (sync, active-high); opcode/funct3/funct7 from IR; zero/negative/carry_out/overflow ALU flags;
//        mem_ack memory handshake; mem_rd_en/mem_wr_en/mem_size memory request; ALU, PC, IR, register-file
//        and address-mux controls; ecall/illegal_instruction one-cycle trap pulses.
module multicycle_control_unit #(
    parameter int XLEN = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic       mem_ack,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic [2:0] mem_size,
    output logic       alua_src,
    output logic       alub_src,
    output logic       aluy_src,
    output logic       sub,
    output logic       arithmetic,
    output logic       alupc_src,
    output logic       pc_src,
    output logic       pc_en,
    output logic       ir_en,
    output logic       wr_reg_en,
    output logic       mem_addr_src,
    output logic [2:0] alu_src,
    output logic [1:0] wr_reg_src,
    output logic       ecall,
    output logic       illegal_instruction
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, MEMORY} state_t;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    state_t state;
    logic is_load, is_store, is_w, is_op, is_imm, mem_ok, taken, branch_ok;
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign is_load  = opcode == OPC_LOAD;
    assign is_store = opcode == OPC_STORE;
    assign is_w     = XLEN == 64 && (opcode == OPC_OP32 || opcode == OPC_IMM32);
    assign is_op    = opcode == OPC_OP || (XLEN == 64 && opcode == OPC_OP32);
    assign is_imm   = opcode == OPC_IMM || (XLEN == 64 && opcode == OPC_IMM32);
    // LD (011) and LWU (110) only exist on RV64; stores allow up to SW (RV32) or SD (RV64)
    assign mem_ok = is_load ? (funct3 != 3'b111 && (XLEN == 64 || (funct3 != 3'b011 && funct3 != 3'b110)))
                            : funct3 < (XLEN == 64 ? 3'd4 : 3'd3);
    // funct3[0] inverts the base condition: BEQ/BNE on zero, BLT/BGE on n^v, BLTU/BGEU on borrow (!carry)
    assign taken     = (funct3[2] ? (funct3[1] ? !carry_out : negative ^ overflow) : zero) ^ funct3[0];
    assign branch_ok = funct3[2:1] != 2'b01;
    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else begin
            case (state)
                FETCH:   state <= mem_ack ? DECODE : FETCH;
                DECODE:  state <= (is_load || is_store) ? MEMORY : EXECUTE;
                EXECUTE: state <= FETCH;
                default: state <= (!mem_ok || mem_ack) ? FETCH : MEMORY;
            endcase
        end
    end
    // outputs are gated by reset so an in-flight request drops in the reset cycle itself
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_size = 3'b000;
        alua_src = 1'b0;
        alub_src = 1'b0;
        aluy_src = 1'b0;
        sub = 1'b0;
        arithmetic = 1'b0;
        alupc_src = 1'b0;
        pc_src = 1'b0;
        pc_en = 1'b0;
        ir_en = 1'b0;
        wr_reg_en = 1'b0;
        mem_addr_src = 1'b0;
        alu_src = 3'b000;
        wr_reg_src = 2'b00;
        ecall = 1'b0;
        illegal_instruction = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_rd_en = 1'b1;
                    mem_size = 3'b010;
                    ir_en = mem_ack;
                end
                DECODE: ;
                EXECUTE: begin
                    pc_en = 1'b1;
                    if (is_op || is_imm) begin
                        alub_src = is_imm;
                        alu_src = funct3;
                        aluy_src = is_w;
                        sub = is_op && funct3 == 3'b000 && funct7[5];
                        arithmetic = funct3 == 3'b101 && funct7[5];
                        wr_reg_en = 1'b1;
                    end else begin
                        case (opcode)
                            OPC_LUI: begin
                                alub_src = 1'b1;
                                wr_reg_en = 1'b1;
                            end
                            OPC_AUIPC: begin
                                alua_src = 1'b1;
                                alub_src = 1'b1;
                                wr_reg_en = 1'b1;
                            end
                            OPC_JAL, OPC_JALR: begin
                                pc_src = 1'b1;
                                alupc_src = opcode == OPC_JALR;
                                wr_reg_src = 2'b11;
                                wr_reg_en = 1'b1;
                            end
                            OPC_BRANCH: begin
                                sub = branch_ok;
                                pc_src = branch_ok && taken;
                                illegal_instruction = !branch_ok;
                            end
                            OPC_FENCE: ;
                            OPC_SYSTEM: begin
                                ecall = funct3 == 3'b000;
                                illegal_instruction = funct3 != 3'b000;
                            end
                            default: illegal_instruction = 1'b1;
                        endcase
                    end
                end
                default: begin
                    if (!mem_ok) begin
                        illegal_instruction = 1'b1;
                        pc_en = 1'b1;
                    end else begin
                        alub_src = 1'b1;
                        mem_addr_src = 1'b1;
                        mem_size = funct3;
                        mem_rd_en = is_load;
                        mem_wr_en = is_store;
                        pc_en = mem_ack;
                        wr_reg_en = is_load && mem_ack;
                        wr_reg_src = (is_load && mem_ack) ? 2'b10 : 2'b00;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed vectors checked against an instruction-level model of the control unit
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       mem_rd_en;
        logic       mem_wr_en;
        logic [2:0] mem_size;
        logic       alua_src;
        logic       alub_src;
        logic       aluy_src;
        logic       sub;
        logic       arithmetic;
        logic       alupc_src;
        logic       pc_src;
        logic       pc_en;
        logic       ir_en;
        logic       wr_reg_en;
        logic       mem_addr_src;
        logic [2:0] alu_src;
        logic [1:0] wr_reg_src;
        logic       ecall;
        logic       illegal_instruction;
    } out_t;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] fl;
        int         w;
    } vec_t;
    localparam out_t Z   = '0;
    localparam out_t F   = '{mem_rd_en: 1'b1, mem_size: 3'b010, default: 0};
    localparam out_t FI  = '{mem_rd_en: 1'b1, mem_size: 3'b010, ir_en: 1'b1, default: 0};
    logic clock = 1'b0;
    logic reset, zero, negative, carry_out, overflow, mem_ack;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic mem_rd_en, mem_wr_en, alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, pc_en;
    logic ir_en, wr_reg_en, mem_addr_src, ecall, illegal_instruction;
    logic [2:0] mem_size, alu_src;
    logic [1:0] wr_reg_src;
    out_t dut_o;
    int total = 0, bad = 0, ph = 0, pcs = 0;
    // ph: 0 awaiting instruction, 1 decode, 2 execute, 3 memory access
    vec_t tbl [23] = '{
        '{7'b0010011, 3'b101, 7'b0100000, 4'b0000, 0},
        '{7'b0010011, 3'b000, 7'b0100000, 4'b0000, 0},
        '{7'b0110011, 3'b101, 7'b0100000, 4'b0000, 0},
        '{7'b0110111, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b0010111, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b1101111, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b1100111, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b1100011, 3'b000, 7'b0000000, 4'b1000, 0},
        '{7'b1100011, 3'b001, 7'b0000000, 4'b1000, 0},
        '{7'b1100011, 3'b100, 7'b0000000, 4'b0100, 0},
        '{7'b1100011, 3'b101, 7'b0000000, 4'b0101, 0},
        '{7'b1100011, 3'b111, 7'b0000000, 4'b0010, 0},
        '{7'b1100011, 3'b010, 7'b0000000, 4'b1111, 0},
        '{7'b0001111, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b1110011, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b1110011, 3'b001, 7'b0000000, 4'b0000, 0},
        '{7'b0111011, 3'b000, 7'b0000000, 4'b0000, 0},
        '{7'b0000011, 3'b000, 7'b0000000, 4'b0000, 1},
        '{7'b0000011, 3'b101, 7'b0000000, 4'b0000, 0},
        '{7'b0000011, 3'b011, 7'b0000000, 4'b0000, 0},
        '{7'b0100011, 3'b010, 7'b0000000, 4'b0000, 2},
        '{7'b0100011, 3'b011, 7'b0000000, 4'b0000, 0},
        '{7'b0100011, 3'b000, 7'b0000000, 4'b0000, 0}
    };
    multicycle_control_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow), .mem_ack(mem_ack),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_size(mem_size), .alua_src(alua_src),
        .alub_src(alub_src), .aluy_src(aluy_src), .sub(sub), .arithmetic(arithmetic), .alupc_src(alupc_src),
        .pc_src(pc_src), .pc_en(pc_en), .ir_en(ir_en), .wr_reg_en(wr_reg_en), .mem_addr_src(mem_addr_src),
        .alu_src(alu_src), .wr_reg_src(wr_reg_src), .ecall(ecall), .illegal_instruction(illegal_instruction)
    );
    assign dut_o = {mem_rd_en, mem_wr_en, mem_size, alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src,
                    pc_src, pc_en, ir_en, wr_reg_en, mem_addr_src, alu_src, wr_reg_src, ecall, illegal_instruction};
    always #5 clock = ~clock;
    function automatic logic mem_legal();
        return opcode == 7'b0000011 ? funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} : funct3 inside {3'd0, 3'd1, 3'd2};
    endfunction
    function automatic out_t model_out();
        out_t o = '0;
        logic [7:0] br;
        br = {carry_out, !carry_out, !(negative ^ overflow), negative ^ overflow, 1'b0, 1'b0, !zero, zero};
        if (reset) return o;
        if (ph == 0) begin
            o.mem_rd_en = 1'b1;
            o.mem_size = 3'b010;
            o.ir_en = mem_ack;
        end else if (ph == 2) begin
            o.pc_en = 1'b1;
            case (opcode)
                7'b0110011, 7'b0010011: begin
                    o.alub_src = opcode == 7'b0010011;
                    o.alu_src = funct3;
                    o.sub = opcode == 7'b0110011 && funct3 == 3'd0 && funct7[5];
                    o.arithmetic = funct3 == 3'd5 && funct7[5];
                    o.wr_reg_en = 1'b1;
                end
                7'b0110111: begin o.alub_src = 1'b1; o.wr_reg_en = 1'b1; end
                7'b0010111: begin o.alua_src = 1'b1; o.alub_src = 1'b1; o.wr_reg_en = 1'b1; end
                7'b1101111: begin o.pc_src = 1'b1; o.wr_reg_src = 2'b11; o.wr_reg_en = 1'b1; end
                7'b1100111: begin o.pc_src = 1'b1; o.alupc_src = 1'b1; o.wr_reg_src = 2'b11; o.wr_reg_en = 1'b1; end
                7'b1100011: begin
                    if (funct3 == 3'd2 || funct3 == 3'd3) o.illegal_instruction = 1'b1;
                    else begin o.sub = 1'b1; o.pc_src = br[funct3]; end
                end
                7'b0001111: ;
                7'b1110011: begin
                    if (funct3 == 3'd0) o.ecall = 1'b1;
                    else o.illegal_instruction = 1'b1;
                end
                default: o.illegal_instruction = 1'b1;
            endcase
        end else if (ph == 3) begin
            if (!mem_legal()) begin
                o.illegal_instruction = 1'b1;
                o.pc_en = 1'b1;
            end else begin
                o.alub_src = 1'b1;
                o.mem_addr_src = 1'b1;
                o.mem_size = funct3;
                o.mem_rd_en = opcode == 7'b0000011;
                o.mem_wr_en = opcode == 7'b0100011;
                if (mem_ack) begin
                    o.pc_en = 1'b1;
                    if (opcode == 7'b0000011) begin o.wr_reg_en = 1'b1; o.wr_reg_src = 2'b10; end
                end
            end
        end
        return o;
    endfunction
    function automatic int next_ph();
        if (reset) return 0;
        case (ph)
            0: return mem_ack ? 1 : 0;
            1: return (opcode == 7'b0000011 || opcode == 7'b0100011) ? 3 : 2;
            2: return 0;
            default: return (!mem_legal() || mem_ack) ? 0 : 3;
        endcase
    endfunction
    task automatic chk(input string nm, input out_t got, input out_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    task automatic chk_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask
    task automatic cyc(input string nm, input out_t lexp);
        @(negedge clock);
        chk($sformatf("model ph=%0d op=%b f3=%b", ph, opcode, funct3), dut_o, model_out());
        if (nm != "") chk(nm, dut_o, lexp);
        if (dut_o.pc_en) pcs++;
        ph = next_ph();
        @(posedge clock);
        #1;
    endtask
    task automatic run_instr(input vec_t v);
        opcode = v.op;
        funct3 = v.f3;
        funct7 = v.f7;
        {zero, negative, carry_out, overflow} = v.fl;
        pcs = 0;
        mem_ack = 1'b1;
        cyc("fetch", FI);
        cyc("", Z);
        for (int i = 0; i < v.w; i++) begin
            mem_ack = 1'b0;
            cyc("", Z);
        end
        mem_ack = 1'b1;
        cyc("", Z);
        chk_int($sformatf("pc_en count op=%b f3=%b", v.op, v.f3), pcs, 1);
    endtask
    initial begin
        reset = 1'b1;
        {opcode, funct3, funct7, zero, negative, carry_out, overflow, mem_ack} = '0;
        cyc("reset", Z);
        reset = 1'b0;
        cyc("fetch wait", F);
        reset = 1'b1;
        cyc("reset mid fetch 1", Z);
        cyc("reset mid fetch 2", Z);
        reset = 1'b0;
        cyc("fetch after reset", F);
        mem_ack = 1'b1;
        opcode = 7'b0110011;
        cyc("add fetch", FI);
        cyc("add decode", Z);
        cyc("add exec", '{wr_reg_en: 1'b1, pc_en: 1'b1, default: 0});
        funct7 = 7'b0100000;
        cyc("sub fetch", FI);
        cyc("sub decode", Z);
        cyc("sub exec", '{sub: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: 0});
        opcode = 7'b0000011;
        funct3 = 3'b010;
        funct7 = 7'b0000000;
        cyc("lw fetch", FI);
        cyc("lw decode", Z);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc("lw wait", '{mem_rd_en: 1'b1, mem_size: 3'b010, alub_src: 1'b1, mem_addr_src: 1'b1, default: 0});
        mem_ack = 1'b1;
        cyc("lw ack", '{mem_rd_en: 1'b1, mem_size: 3'b010, alub_src: 1'b1, mem_addr_src: 1'b1, pc_en: 1'b1,
                        wr_reg_en: 1'b1, wr_reg_src: 2'b10, default: 0});
        opcode = 7'b1100011;
        funct3 = 3'b110;
        carry_out = 1'b0;
        cyc("bltu fetch", FI);
        cyc("bltu decode", Z);
        cyc("bltu taken", '{sub: 1'b1, pc_src: 1'b1, pc_en: 1'b1, default: 0});
        carry_out = 1'b1;
        cyc("bltu2 fetch", FI);
        cyc("bltu2 decode", Z);
        cyc("bltu not taken", '{sub: 1'b1, pc_en: 1'b1, default: 0});
        opcode = 7'b1111111;
        funct3 = 3'b000;
        cyc("illegal fetch", FI);
        cyc("illegal decode", Z);
        cyc("illegal exec", '{illegal_instruction: 1'b1, pc_en: 1'b1, default: 0});
        opcode = 7'b0100011;
        funct3 = 3'b010;
        pcs = 0;
        cyc("sw fetch", FI);
        cyc("sw decode", Z);
        mem_ack = 1'b0;
        cyc("sw request", '{mem_wr_en: 1'b1, mem_size: 3'b010, alub_src: 1'b1, mem_addr_src: 1'b1, default: 0});
        reset = 1'b1;
        cyc("sw reset", Z);
        reset = 1'b0;
        cyc("sw refetch", F);
        chk_int("sw no pc_en", pcs, 0);
        for (int i = 0; i < 23; i++) run_instr(tbl[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control unit that sequences the RV32I/RV64I dataflow, one instruction at a time.
- Drives every dataflow control input (ALU muxes, PC/IR enables, register write, memory address select, trap requests).
- Owns the memory request handshake shared by instruction fetch and load/store.
- Sits beside the dataflow in the core top level; decodes from opcode/funct3/funct7 and the ALU flags.

Parameters:
XLEN, 32, datapath width. 64 enables OP-IMM-32/OP-32 (opcodes 0011011/0111011), LD/SD/LWU and the aluy_src output.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
opcode  input  7  ir[6:0]
funct3  input  3  ir[14:12]
funct7  input  7  ir[31:25]
zero, negative, carry_out, overflow  input  1 each  ALU flags
mem_ack  input  1  memory completed current request (may be high in the request cycle)
mem_rd_en  output  1  memory read request
mem_wr_en  output  1  memory write request
mem_size  output  3  funct3 of the load/store; 010 during fetch
alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, pc_en, ir_en, wr_reg_en, mem_addr_src  output  1 each  dataflow controls
alu_src  output  3  ALU select
wr_reg_src  output  2  00 aluY, 10 rd_data, 11 pc+4
ecall, illegal_instruction  output  1 each  trap requests, one-cycle pulse

Behaviour:
- Reset (synchronous, active-high): state=FETCH, all outputs 0.
  - Reset asserted mid-request drops mem_rd_en/mem_wr_en in the same cycle; no pc_en, ir_en or wr_reg_en is issued.
- All outputs are combinational from state, IR fields and mem_ack. Default value of every output is 0.
- FETCH:
  - mem_addr_src=0, mem_rd_en=1, mem_size=010.
  - On mem_ack: ir_en=1, go to DECODE. Otherwise hold.
- DECODE: one cycle, no outputs. Next state is EXECUTE, or MEMORY for load (0000011) and store (0100011).
- EXECUTE: single cycle, pc_en=1, then FETCH. Per opcode:
  - OP (0110011): alu_src=funct3; sub=funct7[5] when funct3=000; arithmetic=funct7[5] when funct3=101; wr_reg_en=1.
  - OP-IMM (0010011): alub_src=1, alu_src=funct3; arithmetic=funct7[5] when funct3=101; sub=0; wr_reg_en=1.
  - LUI: alub_src=1, alu_src=000, wr_reg_en=1.
  - AUIPC: alua_src=1, alub_src=1, alu_src=000, wr_reg_en=1.
  - JAL: pc_src=1, wr_reg_src=11, wr_reg_en=1.
  - JALR: pc_src=1, alupc_src=1, wr_reg_src=11, wr_reg_en=1.
  - BRANCH (1100011): sub=1, alu_src=000, operands rs1/rs2. pc_src by funct3:
    - BEQ: zero
    - BNE: !zero
    - BLT: negative^overflow
    - BGE: !(negative^overflow)
    - BLTU: !carry_out
    - BGEU: carry_out
    - funct3 010/011: illegal.
  - FENCE (0001111): pc_en only.
  - SYSTEM funct3=000: ecall=1. Any other SYSTEM funct3 is illegal.
  - XLEN=64, *-32 opcodes: as OP/OP-IMM plus aluy_src=1.
  - Any other opcode: illegal_instruction=1 with pc_en=1. No wr_reg_en, no memory access.
- MEMORY:
  - alub_src=1, alu_src=000, mem_addr_src=1, mem_size=funct3.
  - Load: mem_rd_en=1. Store: mem_wr_en=1. Request held until mem_ack.
  - On mem_ack: pc_en=1. Load also asserts wr_reg_en=1, wr_reg_src=10. Then go to FETCH.
  - Load funct3 011/110/111, store funct3 ≥011 (XLEN=32) or ≥100 (XLEN=64): illegal in MEMORY's first cycle, no request issued, go to FETCH.
- mem_ack is ignored in DECODE/EXECUTE. mem_rd_en and mem_wr_en are never both high.
- Latency with zero-wait memory: 3 cycles per instruction. Each wait cycle adds 1.
- pc_en is asserted exactly once per instruction, including trap cycles.

Test Plan:
- Reset held 2 cycles mid-FETCH with mem_ack=0 -> all outputs 0 during reset; mem_rd_en=1 on the first cycle after release.
- ADD then SUB (opcode 0110011, funct7 0000000 / 0100000), mem_ack tied 1 -> ir_en in cycle 0; EXECUTE in cycle 2 with sub=0 / sub=1, wr_reg_en=1, pc_en=1; 3 cycles each.
- LW with mem_ack delayed 4 cycles in MEMORY -> mem_rd_en held 5 cycles with mem_size=010; wr_reg_en=1, wr_reg_src=10, pc_en=1 only in the ack cycle.
- BLTU with carry_out=0, then carry_out=1 -> pc_src=1, then pc_src=0; wr_reg_en=0 both times.
- opcode 1111111 -> illegal_instruction=1 and pc_en=1 for 1 cycle; no memory request; returns to FETCH.
- SW with reset asserted while mem_wr_en=1 -> mem_wr_en=0 that cycle; FSM in FETCH afterwards; no pc_en pulse.
